llsc_mem_responder: RTL

Memory-side responder for the datapath's data-memory request interface: it services the read, write and atomic strobes that the decode stage raises for LW/SW/LL/SC and answers with a single-cycle `dhit`. It owns the load-link reservation register and resolves SC success or failure locally. It drives a single-port RAM that can insert wait states, and it accepts a coherence snoop that can break the reservation. It sits between the datapath and the RAM/bus controller.

---
 rtl/llsc_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/llsc_mem_responder.sv
// llsc_mem_responder
// Data-memory responder for LW/SW/LL/SC. It services one datapath request at a
// time against a single-port RAM that may insert wait states. It owns the
// load-link reservation and resolves SC locally, so a failing SC never
// touches the RAM.
//
// Ports
//   CLK, RST                  clock, async active-high reset
//   dREN, dWEN, atomic        datapath request (LW/LL read, SW/SC write)
//   daddr, dstore             request byte address and write data
//   dhit, dmemload            one-cycle completion pulse, load data / SC result
//   ramREN, ramWEN            RAM strobes, held until ram_ready
//   ramaddr, ramstore         RAM address / write data, stable during access
//   ramload, ram_ready        RAM read data and access-complete flag
//   snoop_inv, snoop_addr     external write that can break the reservation
//
// state  | meaning
// IDLE   | sample request, resolve SC against the reservation
// ACCESS | RAM strobe asserted, waiting for ram_ready
// DONE   | dhit pulse, result on dmemload
module llsc_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              atomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state;
  logic              req_wr;
  logic              req_atomic;
  logic              link_v;
  logic [ADDR_W-3:0] link_addr;

  logic [ADDR_W-3:0] d_word;
  logic [ADDR_W-3:0] s_word;
  logic [ADDR_W-3:0] r_word;
  logic              sc_req;
  logic              sc_ok;
  logic              ll_done;
  logic              sw_done;
  logic              snoop_unused;

  assign d_word = daddr[ADDR_W-1:2];
  assign s_word = snoop_addr[ADDR_W-1:2];
  assign r_word = ramaddr[ADDR_W-1:2];
  assign snoop_unused = ^snoop_addr[1:0];

  assign sc_req = (state == IDLE) && dWEN && atomic;
  // A snoop to the SC's own word in the sampling cycle kills the SC.
  assign sc_ok  = link_v && (link_addr == d_word) && !(snoop_inv && (s_word == d_word));

  assign ll_done = (state == ACCESS) && ram_ready && !req_wr && req_atomic;
  assign sw_done = (state == ACCESS) && ram_ready && req_wr && !req_atomic;

  // Outputs are purely state-decoded or registered.
  assign dhit   = (state == DONE);
  assign ramREN = (state == ACCESS) && !req_wr;
  assign ramWEN = (state == ACCESS) && req_wr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      req_wr     <= 1'b0;
      req_atomic <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
      dmemload   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            // dWEN wins when both strobes are raised.
            req_wr     <= dWEN;
            req_atomic <= atomic;
            ramaddr    <= daddr;
            ramstore   <= dstore;
            if (dWEN && atomic) begin
              dmemload <= {{(DATA_W-1){1'b0}}, sc_ok};
              state    <= sc_ok ? ACCESS : DONE;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            if (!req_wr) dmemload <= ramload;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_v    <= 1'b0;
      link_addr <= '0;
    end else begin
      if (ll_done) begin
        // A snoop to the word being linked in the same cycle wins.
        link_v    <= !(snoop_inv && (s_word == r_word));
        link_addr <= r_word;
      end else if (sc_req ||
                   (sw_done && (link_addr == r_word)) ||
                   (snoop_inv && (s_word == link_addr))) begin
        link_v <= 1'b0;
      end
    end
  end

endmodule
